// File: rtl/rotation_angle_ctrl.sv
// Rotation angle sequencer for the pixel-mapping datapath.
// Auto/manual angle updates, committed only at frame boundaries.
module rotation_angle_ctrl #(
    parameter int TICK_DIV      = 5000000,
    parameter int ANGLE_STEPS   = 71,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       iENABLE,
    input  logic [5:0] iSTEP,
    input  logic       iFRAME_SYNC,
    output logic [6:0] oTHETA,
    output logic       oTHETA_VALID,
    output logic       oUPDATE,
    output logic       oBUSY,
    output logic       oMISSED
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0] STEPS8 = 8'(ANGLE_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        LOAD,
        SETTLE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [SW-1:0] settle_q;
    logic          pending_q;
    logic          tick;
    logic          cancel;
    logic          settle_done;
    logic [7:0]    sum;
    logic [7:0]    raw;
    logic [7:0]    wrapped;
    logic [6:0]    next_theta;

    assign tick        = iENABLE && (presc_q == PRESC_LAST);
    assign cancel      = (state_q == WAIT_FRAME) && !iENABLE
                         && ({1'b0, iSTEP} == oTHETA);
    assign settle_done = (state_q == SETTLE) && (settle_q == SETTLE_LAST);

    // Next angle: auto adds the step modulo ANGLE_STEPS, manual takes the switch value.
    always_comb begin
        sum        = {1'b0, oTHETA} + {2'b00, iSTEP};
        raw        = iENABLE ? sum : {2'b00, iSTEP};
        wrapped    = (raw >= STEPS8) ? (raw - STEPS8) : raw;
        next_theta = wrapped[6:0];
    end

    // Next-state logic; sync is only honoured while waiting for a frame boundary.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (pending_q) state_d = WAIT_FRAME;
            WAIT_FRAME: begin
                if (cancel)           state_d = IDLE;
                else if (iFRAME_SYNC) state_d = LOAD;
            end
            LOAD:       state_d = SETTLE;
            SETTLE:     if (settle_done) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Auto-rotate prescaler, parked at zero in manual mode.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)      presc_q <= '0;
        else if (!iENABLE) presc_q <= '0;
        else if (tick)     presc_q <= '0;
        else               presc_q <= presc_q + 1'b1;
    end

    // Pending request flag; extra ticks are dropped rather than accumulated.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= 1'b0;
            oMISSED   <= 1'b0;
        end else begin
            oMISSED <= tick && pending_q;
            if (state_q == LOAD || cancel)
                pending_q <= 1'b0;
            else if (tick)
                pending_q <= 1'b1;
            else if (!iENABLE && state_q == IDLE
                     && {1'b0, iSTEP} != oTHETA)
                pending_q <= 1'b1;
        end
    end

    // Settle counter covering the trig LUT read latency.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                settle_q <= '0;
        else if (state_q == LOAD)    settle_q <= '0;
        else if (state_q == SETTLE)  settle_q <= settle_q + 1'b1;
    end

    // Registered outputs: angle commits in LOAD, valid drops on entering LOAD.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            oTHETA       <= '0;
            oTHETA_VALID <= 1'b1;
            oUPDATE      <= 1'b0;
            oBUSY        <= 1'b0;
        end else begin
            oBUSY   <= (state_d != IDLE);
            oUPDATE <= settle_done;
            if (state_q == LOAD)
                oTHETA <= next_theta;
            if (state_d == LOAD)
                oTHETA_VALID <= 1'b0;
            else if (settle_done)
                oTHETA_VALID <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rotation_angle_ctrl.sv
// Self-checking bench for rotation_angle_ctrl.
// Table-driven updates plus directed multi-cycle corner cases.
module tb_rotation_angle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [5:0] step = '0;
    logic [6:0] theta;
    logic       valid;
    logic       update;
    logic       busy;
    logic       missed;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic [5:0] step;
        logic [6:0] exp;
        int         hold;
    } vec_t;

    vec_t vecs[14];

    rotation_angle_ctrl #(
        .TICK_DIV(4),
        .ANGLE_STEPS(71),
        .SETTLE_CYCLES(2)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .iENABLE(en),
        .iSTEP(step),
        .iFRAME_SYNC(sync),
        .oTHETA(theta),
        .oTHETA_VALID(valid),
        .oUPDATE(update),
        .oBUSY(busy),
        .oMISSED(missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Request an update, optionally hold off the sync, then check the load/settle timing.
    task automatic run_update(input logic e, input logic [5:0] st,
                              input logic [6:0] exp, input int hold,
                              input string nm);
        logic [6:0] old;
        int n;
        int bad;
        bit lowok;
        en = e;
        step = st;
        n = 0;
        @(negedge clk);
        while (!busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_busy"}, int'(busy), 1);
        old = theta;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!busy || theta != old) bad++;
        end
        if (hold > 0) chk({nm, "_hold"}, bad, 0);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        lowok = !valid && (theta == old);
        @(negedge clk);
        chk({nm, "_theta"}, int'(theta), int'(exp));
        lowok = lowok && !valid && !update;
        @(negedge clk);
        lowok = lowok && !valid && !update;
        @(negedge clk);
        chk({nm, "_vlow"}, int'(lowok), 1);
        chk({nm, "_vup"}, int'({valid, update}), 3);
        @(negedge clk);
        chk({nm, "_pulse"}, int'(update), 0);
    endtask

    initial begin
        int cnt;
        int bad;
        vecs[0]  = '{1'b1, 6'd10, 7'd10, 0};
        vecs[1]  = '{1'b1, 6'd10, 7'd20, 0};
        vecs[2]  = '{1'b1, 6'd50, 7'd70, 0};
        vecs[3]  = '{1'b1, 6'd1,  7'd0,  0};
        vecs[4]  = '{1'b1, 6'd0,  7'd0,  0};
        vecs[5]  = '{1'b1, 6'd63, 7'd63, 0};
        vecs[6]  = '{1'b1, 6'd8,  7'd0,  0};
        vecs[7]  = '{1'b0, 6'd30, 7'd30, 100};
        vecs[8]  = '{1'b0, 6'd0,  7'd0,  0};
        vecs[9]  = '{1'b1, 6'd60, 7'd60, 0};
        vecs[10] = '{1'b1, 6'd11, 7'd0,  0};
        vecs[11] = '{1'b1, 6'd60, 7'd60, 0};
        vecs[12] = '{1'b1, 6'd5,  7'd65, 0};
        vecs[13] = '{1'b1, 6'd10, 7'd4,  0};

        repeat (2) @(negedge clk);
        chk("rst_theta", int'(theta), 0);
        chk("rst_valid", int'(valid), 1);
        chk("rst_flags", int'({update, busy, missed}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_update(vecs[i].en, vecs[i].step, vecs[i].exp,
                       vecs[i].hold, $sformatf("vec%0d", i));

        en = 1'b0;
        step = 6'd4;
        repeat (3) @(negedge clk);
        chk("quiet_busy", int'(busy), 0);

        en = 1'b1;
        step = 6'd3;
        cnt = 0;
        repeat (13) begin
            @(negedge clk);
            if (missed) cnt++;
        end
        chk("missed_cnt", cnt, 2);
        run_update(1'b1, 6'd3, 7'd7, 0, "missed_one_step");

        en = 1'b0;
        step = 6'd7;
        repeat (3) @(negedge clk);
        chk("quiet2_busy", int'(busy), 0);
        step = 6'd40;
        repeat (2) @(negedge clk);
        chk("cancel_pre_busy", int'(busy), 1);
        step = 6'd7;
        repeat (2) @(negedge clk);
        chk("cancel_busy", int'(busy), 0);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (update || busy || theta != 7'd7) bad++;
        end
        chk("cancel_noload", bad, 0);

        en = 1'b1;
        step = 6'd2;
        repeat (3) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (update || theta != 7'd7) bad++;
        end
        chk("tick_sync_noload", bad, 0);
        chk("tick_sync_busy", int'(busy), 1);
        run_update(1'b1, 6'd2, 7'd9, 0, "tick_sync_next");

        en = 1'b0;
        step = 6'd9;
        repeat (3) @(negedge clk);
        chk("quiet3_busy", int'(busy), 0);
        step = 6'd30;
        cnt = 0;
        while (!busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_seq_busy", int'(busy), 1);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        chk("rst_seq_theta", int'(theta), 30);
        rst_n = 1'b0;
        #1;
        chk("async_theta", int'(theta), 0);
        chk("async_valid", int'(valid), 1);
        chk("async_busy", int'(busy), 0);
        step = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (update || !valid || theta != 7'd0) bad++;
        end
        chk("post_rst_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
